// File: rtl/axis_reg_capture.sv
// ----------------------------------------------------------------------------
// axis_reg_capture
//
// Purpose:
//   AXI-Stream sink that captures one accepted beat out of every DECIM into a
//   holding register. The register is held until the next capture. Sticky
//   flags tell the consumer that a capture is pending and that a capture
//   overwrote data it had not yet acknowledged.
//
// Parameters:
//   DIN_WIDTH      width of the stream payload and of data_out
//   DECIM          decimation ratio (1..65535); DECIM=1 captures every beat
//
// Ports:
//   aclk           sole clock, all logic on the rising edge
//   aresetn        asynchronous active-low reset
//   enable         synchronous run enable (IDLE <-> RUN)
//   s_axis_tdata   stream payload
//   s_axis_tvalid  payload valid
//   s_axis_tready  sink ready; high only in RUN, registered
//   ack            consumer acknowledge, clears data_valid
//   overrun_clr    clears overrun
//   data_out       last captured payload
//   data_valid     sticky: an unacknowledged capture is present
//   update         one-cycle pulse in the first cycle data_out shows new data
//   overrun        sticky: a capture happened while data_valid was set
//   capture_count  number of captures, modulo 2^16
// ----------------------------------------------------------------------------
module axis_reg_capture #(
   parameter int unsigned DIN_WIDTH = 16,
   parameter int unsigned DECIM     = 1
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 enable,
   input  logic [DIN_WIDTH-1:0] s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic                 ack,
   input  logic                 overrun_clr,
   output logic [DIN_WIDTH-1:0] data_out,
   output logic                 data_valid,
   output logic                 update,
   output logic                 overrun,
   output logic [15:0]          capture_count
);

   // Decimation counter sized for 0..DECIM-1; at least one bit so DECIM=1
   // still yields a legal (constant-zero) counter.
   localparam int unsigned      CNT_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DECIM - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [15:0]      CAP_ONE = 16'd1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t               r_state;
   logic                 r_tready;
   logic [CNT_W-1:0]     r_cnt;
   logic [DIN_WIDTH-1:0] r_data;
   logic                 r_valid;
   logic                 r_update;
   logic                 r_overrun;
   logic [15:0]          r_count;

   logic                 w_accept;
   logic                 w_capture;
   logic                 w_overrun_set;

   // Handshake and capture qualification. tready comes from a register, so
   // acceptance never feeds back combinationally into tready.
   always_comb begin
      w_accept      = s_axis_tvalid & r_tready;
      w_capture     = w_accept & (r_cnt == CNT_MAX);
      // A capture acknowledged on the same edge does not count as an overrun.
      w_overrun_set = w_capture & r_valid & ~ack;
   end

   // Run/idle state machine; tready is registered alongside the state so it
   // is high exactly while the machine is in RUN.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state  <= ST_IDLE;
         r_tready <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (enable) begin
                  r_state  <= ST_RUN;
                  r_tready <= 1'b1;
               end else begin
                  r_state  <= ST_IDLE;
                  r_tready <= 1'b0;
               end
            end
            ST_RUN: begin
               if (!enable) begin
                  r_state  <= ST_IDLE;
                  r_tready <= 1'b0;
               end else begin
                  r_state  <= ST_RUN;
                  r_tready <= 1'b1;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_tready <= 1'b0;
            end
         endcase
      end
   end

   // Decimation counter: held at zero in IDLE so a partial count from an
   // interrupted run never carries into the next run.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_cnt <= '0;
      end else if (r_state == ST_IDLE) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // Capture register, update pulse and capture counter. Leaving RUN does
   // not touch the captured data or the count.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_data   <= '0;
         r_update <= 1'b0;
         r_count  <= 16'd0;
      end else if (w_capture) begin
         r_data   <= s_axis_tdata;
         r_update <= 1'b1;
         r_count  <= r_count + CAP_ONE;
      end else begin
         r_data   <= r_data;
         r_update <= 1'b0;
         r_count  <= r_count;
      end
   end

   // Sticky flags: a capture takes priority over the clear that shares
   // its edge, for both data_valid and overrun.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_capture) begin
            r_valid <= 1'b1;
         end else if (ack) begin
            r_valid <= 1'b0;
         end else begin
            r_valid <= r_valid;
         end

         if (w_overrun_set) begin
            r_overrun <= 1'b1;
         end else if (overrun_clr) begin
            r_overrun <= 1'b0;
         end else begin
            r_overrun <= r_overrun;
         end
      end
   end

   assign s_axis_tready = r_tready;
   assign data_out      = r_data;
   assign data_valid    = r_valid;
   assign update        = r_update;
   assign overrun       = r_overrun;
   assign capture_count = r_count;

endmodule

// File: tb/tb_axis_reg_capture.sv
module tb_axis_reg_capture;

   logic        aclk;
   logic        aresetn;
   logic        enable;
   logic [15:0] tdata;
   logic        tvalid;
   logic        ack;
   logic        oclr;

   logic        rdy   [2];
   logic [15:0] dout  [2];
   logic        vld   [2];
   logic        upd   [2];
   logic        ovr   [2];
   logic [15:0] cnt   [2];

   int n_checks = 0;
   int n_errors = 0;

   // Instance 0 decimates by 1, instance 1 by 4; both see the same stream.
   int DEC [2] = '{1, 4};

   axis_reg_capture #(.DIN_WIDTH(16), .DECIM(1)) u_dut1 (
      .aclk(aclk), .aresetn(aresetn), .enable(enable),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(rdy[0]),
      .ack(ack), .overrun_clr(oclr),
      .data_out(dout[0]), .data_valid(vld[0]), .update(upd[0]),
      .overrun(ovr[0]), .capture_count(cnt[0])
   );

   axis_reg_capture #(.DIN_WIDTH(16), .DECIM(4)) u_dut4 (
      .aclk(aclk), .aresetn(aresetn), .enable(enable),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(rdy[1]),
      .ack(ack), .overrun_clr(oclr),
      .data_out(dout[1]), .data_valid(vld[1]), .update(upd[1]),
      .overrun(ovr[1]), .capture_count(cnt[1])
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Reference model: tracks how many beats were accepted in the current run;
   // the beat whose index is DECIM-1 modulo DECIM is captured.
   logic        m_run  [2];
   int          m_nacc [2];
   logic [15:0] m_data [2];
   logic        m_vld  [2];
   logic        m_upd  [2];
   logic        m_ovr  [2];
   logic [15:0] m_cnt  [2];

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         m_run[k] = 1'b0; m_nacc[k] = 0; m_data[k] = 16'h0000;
         m_vld[k] = 1'b0; m_upd[k] = 1'b0; m_ovr[k] = 1'b0; m_cnt[k] = 16'h0000;
      end
   endtask

   task automatic m_step(input logic en, input logic tv, input logic [15:0] d,
                         input logic a, input logic c);
      for (int k = 0; k < 2; k++) begin
         bit acc, cap, oset;
         acc  = m_run[k] && tv;
         cap  = acc && ((m_nacc[k] % DEC[k]) == DEC[k] - 1);
         oset = cap && m_vld[k] && !a;
         if (!m_run[k]) m_nacc[k] = 0;
         else if (acc) m_nacc[k] = m_nacc[k] + 1;
         m_upd[k] = cap;
         if (cap) begin
            m_data[k] = d;
            m_cnt[k]  = m_cnt[k] + 16'd1;
         end
         if (cap) m_vld[k] = 1'b1;
         else if (a) m_vld[k] = 1'b0;
         if (oset) m_ovr[k] = 1'b1;
         else if (c) m_ovr[k] = 1'b0;
         m_run[k] = en;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      for (int k = 0; k < 2; k++) begin
         string p;
         p = $sformatf("%s.d%0d", tag, DEC[k]);
         chk({p, ".tready"}, 32'(rdy[k]),  32'(m_run[k]));
         chk({p, ".data"},   32'(dout[k]), 32'(m_data[k]));
         chk({p, ".valid"},  32'(vld[k]),  32'(m_vld[k]));
         chk({p, ".update"}, 32'(upd[k]),  32'(m_upd[k]));
         chk({p, ".overrun"},32'(ovr[k]),  32'(m_ovr[k]));
         chk({p, ".count"},  32'(cnt[k]),  32'(m_cnt[k]));
      end
   endtask

   // One clock: drive on the falling edge, step the model on the rising
   // edge, compare 1 time unit later.
   task automatic cycle(input string tag, input logic en, input logic tv,
                        input logic [15:0] d, input logic a, input logic c);
      @(negedge aclk);
      enable = en; tvalid = tv; tdata = d; ack = a; oclr = c;
      @(posedge aclk);
      m_step(en, tv, d, a, c);
      #1;
      chk_model(tag);
   endtask

   task automatic do_reset();
      @(negedge aclk);
      enable = 1'b0; tvalid = 1'b0; tdata = 16'h0000; ack = 1'b0; oclr = 1'b0;
      aresetn = 1'b0;
      m_reset();
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
   endtask

   typedef struct {
      logic        en, tv;
      logic [15:0] d;
      logic        a, c;
      logic        e_rdy;
      logic [15:0] e_dout;
      logic        e_vld, e_upd, e_ovr;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs [16];

   initial begin
      // Expected values for the DECIM=1 instance, cycle by cycle from reset.
      vecs[0]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0, 1'b1,16'h0000,1'b0,1'b0,1'b0,16'd0};
      vecs[1]  = '{1'b1,1'b1,16'h0001,1'b0,1'b0, 1'b1,16'h0001,1'b1,1'b1,1'b0,16'd1};
      vecs[2]  = '{1'b1,1'b1,16'h0002,1'b0,1'b0, 1'b1,16'h0002,1'b1,1'b1,1'b1,16'd2};
      vecs[3]  = '{1'b1,1'b1,16'h0003,1'b0,1'b0, 1'b1,16'h0003,1'b1,1'b1,1'b1,16'd3};
      vecs[4]  = '{1'b1,1'b0,16'h0000,1'b1,1'b0, 1'b1,16'h0003,1'b0,1'b0,1'b1,16'd3};
      vecs[5]  = '{1'b1,1'b0,16'h0000,1'b0,1'b1, 1'b1,16'h0003,1'b0,1'b0,1'b0,16'd3};
      vecs[6]  = '{1'b1,1'b1,16'h0044,1'b1,1'b0, 1'b1,16'h0044,1'b1,1'b1,1'b0,16'd4};
      vecs[7]  = '{1'b1,1'b1,16'h0055,1'b1,1'b0, 1'b1,16'h0055,1'b1,1'b1,1'b0,16'd5};
      vecs[8]  = '{1'b1,1'b0,16'h0000,1'b1,1'b0, 1'b1,16'h0055,1'b0,1'b0,1'b0,16'd5};
      vecs[9]  = '{1'b1,1'b1,16'h0066,1'b0,1'b0, 1'b1,16'h0066,1'b1,1'b1,1'b0,16'd6};
      vecs[10] = '{1'b1,1'b1,16'h0077,1'b0,1'b1, 1'b1,16'h0077,1'b1,1'b1,1'b1,16'd7};
      vecs[11] = '{1'b1,1'b0,16'h0000,1'b0,1'b1, 1'b1,16'h0077,1'b1,1'b0,1'b0,16'd7};
      vecs[12] = '{1'b0,1'b1,16'h0088,1'b0,1'b0, 1'b0,16'h0088,1'b1,1'b1,1'b1,16'd8};
      vecs[13] = '{1'b0,1'b1,16'h0099,1'b0,1'b0, 1'b0,16'h0088,1'b1,1'b0,1'b1,16'd8};
      vecs[14] = '{1'b0,1'b0,16'h0000,1'b1,1'b1, 1'b0,16'h0088,1'b0,1'b0,1'b0,16'd8};
      vecs[15] = '{1'b0,1'b0,16'h0000,1'b1,1'b1, 1'b0,16'h0088,1'b0,1'b0,1'b0,16'd8};

      aresetn = 1'b0;
      enable = 1'b0; tvalid = 1'b0; tdata = 16'h0000; ack = 1'b0; oclr = 1'b0;
      m_reset();
      #1;
      chk_model("reset");
      do_reset();

      // Table-driven sequence on the DECIM=1 instance.
      for (int i = 0; i < 16; i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         cycle(t, vecs[i].en, vecs[i].tv, vecs[i].d, vecs[i].a, vecs[i].c);
         chk({t, ".tready"},  32'(rdy[0]),  32'(vecs[i].e_rdy));
         chk({t, ".data"},    32'(dout[0]), 32'(vecs[i].e_dout));
         chk({t, ".valid"},   32'(vld[0]),  32'(vecs[i].e_vld));
         chk({t, ".update"},  32'(upd[0]),  32'(vecs[i].e_upd));
         chk({t, ".overrun"}, 32'(ovr[0]),  32'(vecs[i].e_ovr));
         chk({t, ".count"},   32'(cnt[0]),  32'(vecs[i].e_cnt));
      end

      // DECIM=4: eight beats 0x10..0x17 capture only 0x13 and 0x17.
      do_reset();
      cycle("dec4.en", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cycle("dec4.beat", 1'b1, 1'b1, 16'(16'h0010 + i), 1'b0, 1'b0);
         chk($sformatf("dec4.upd%0d", i), 32'(upd[1]), (i == 3 || i == 7) ? 32'd1 : 32'd0);
      end
      chk("dec4.data",  32'(dout[1]), 32'h0017);
      chk("dec4.count", 32'(cnt[1]),  32'd2);

      // Disable after two beats, re-enable, four fresh beats: only 0xA3 lands.
      do_reset();
      cycle("dis.en", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      cycle("dis.b0", 1'b1, 1'b1, 16'h0030, 1'b0, 1'b0);
      cycle("dis.b1", 1'b1, 1'b1, 16'h0031, 1'b0, 1'b0);
      cycle("dis.off", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle("dis.idle", 1'b0, 1'b1, 16'h0032, 1'b0, 1'b0);
         chk("dis.tready", 32'(rdy[1]), 32'd0);
         chk("dis.noupd",  32'(upd[1]), 32'd0);
      end
      cycle("dis.reen", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle("dis.a", 1'b1, 1'b1, 16'(16'h00A0 + i), 1'b0, 1'b0);
         chk($sformatf("dis.upd%0d", i), 32'(upd[1]), (i == 3) ? 32'd1 : 32'd0);
      end
      chk("dis.data",  32'(dout[1]), 32'h00A3);
      chk("dis.count", 32'(cnt[1]),  32'd1);

      // Asynchronous reset in the middle of a stream holding 0x5A5A.
      do_reset();
      cycle("ar.en", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      cycle("ar.b0", 1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0);
      cycle("ar.b1", 1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0);
      chk("ar.pre", 32'(dout[0]), 32'h5A5A);
      @(negedge aclk);
      #2;
      aresetn = 1'b0;
      m_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("ar.tready", 32'(rdy[k]),  32'd0);
         chk("ar.data",   32'(dout[k]), 32'd0);
         chk("ar.valid",  32'(vld[k]),  32'd0);
         chk("ar.update", 32'(upd[k]),  32'd0);
         chk("ar.overrun",32'(ovr[k]),  32'd0);
         chk("ar.count",  32'(cnt[k]),  32'd0);
      end
      @(negedge aclk);
      enable = 1'b0; ack = 1'b0; oclr = 1'b0;
      aresetn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle("ar.off", 1'b0, 1'b1, 16'h1111, 1'b0, 1'b0);
         chk("ar.off.tready", 32'(rdy[0]), 32'd0);
      end
      cycle("ar.on", 1'b1, 1'b1, 16'h2222, 1'b0, 1'b0);
      chk("ar.on.tready", 32'(rdy[0]), 32'd1);
      chk("ar.on.count",  32'(cnt[0]), 32'd0);
      cycle("ar.beat", 1'b1, 1'b1, 16'h3333, 1'b0, 1'b0);
      chk("ar.beat.data", 32'(dout[0]), 32'h3333);

      // Randomised traffic against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle("rnd", ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
               16'($urandom()), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/axis_reg_capture.md
AXIS_REG_CAPTURE -- requirements
Module: axis_reg_capture

Interface
REQ-001 Parameter DIN_WIDTH, default 16: width of the stream data and the captured register.
REQ-002 Parameter DECIM, default 1, legal range 1..65535: one beat in every DECIM accepted beats is captured.
REQ-003 aclk  input  1  sole clock; all logic is rising-edge.
REQ-004 aresetn  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  capture enable; synchronous.
REQ-006 s_axis_tdata  input  DIN_WIDTH  stream payload.
REQ-007 s_axis_tvalid  input  1  payload valid.
REQ-008 s_axis_tready  output  1  sink ready.
REQ-009 ack  input  1  consumer acknowledge; one-cycle pulse clears data_valid.
REQ-010 overrun_clr  input  1  clears overrun.
REQ-011 data_out  output  DIN_WIDTH  last captured payload, held until the next capture.
REQ-012 data_valid  output  1  sticky flag: unacknowledged capture present.
REQ-013 update  output  1  one-cycle pulse in the cycle data_out first shows new data.
REQ-014 overrun  output  1  sticky flag: a capture occurred while data_valid=1.
REQ-015 capture_count  output  16  number of captures, wraps 0xFFFF->0x0000.

Function
REQ-016 Two states, IDLE and RUN; reset enters IDLE.
REQ-017 IDLE->RUN on the first clock edge with enable=1; RUN->IDLE on the first clock edge with enable=0.
REQ-018 s_axis_tready = 1 only in RUN (registered state); it is 0 in IDLE and during reset.
REQ-019 A beat is accepted when s_axis_tvalid=1 and s_axis_tready=1 on the same rising edge; tready does not depend combinationally on tvalid.
REQ-020 Decimation counter range 0..DECIM-1: increments on each accepted beat, wraps to 0 after DECIM-1, and is cleared to 0 in IDLE.
REQ-021 A capture occurs on an accepted beat when the counter = DECIM-1; with DECIM=1 every accepted beat is captured.
REQ-022 On a capture, data_out loads s_axis_tdata at that edge; update=1 for exactly the following cycle.
REQ-023 Latency from beat acceptance edge to data_out/update visible: 1 cycle.
REQ-024 A capture sets data_valid; ack=1 clears it; if capture and ack fall on the same edge, data_valid stays 1.
REQ-025 A capture while data_valid=1 and ack=0 sets overrun; data_out is still overwritten with the newer data.
REQ-026 overrun_clr=1 clears overrun; a simultaneous overrun-setting capture wins and overrun stays 1.
REQ-027 capture_count increments by 1 per capture, modulo 2^16.
REQ-028 Entering IDLE leaves data_out, data_valid, overrun and capture_count unchanged.
REQ-029 Beats presented with s_axis_tvalid=1 in IDLE are not accepted and have no effect.
REQ-030 ack or overrun_clr with no flag set has no effect.

Reset
REQ-031 aresetn=0 asynchronously forces: state=IDLE, s_axis_tready=0, data_out=0, data_valid=0, update=0, overrun=0, capture_count=0, decimation counter=0.
REQ-032 aresetn asserted mid-stream discards any partial decimation count; after release the block re-enters RUN only on an edge with enable=1.
REQ-033 Reset release is synchronised to aclk by the integrating design; the block itself adds no synchroniser.

Structure
REQ-034 State encodings and the counter width are local constants; nothing is placed in a shared package.
REQ-035 Single flat module; no sub-module is required.

Verification
REQ-036 DECIM=1, enable=1, continuous tvalid with tdata 0x0001,0x0002,0x0003 -> data_out follows with 1-cycle lag, update high for 3 cycles, capture_count=3, overrun=1 after the 2nd capture.
REQ-037 DECIM=4, 8 beats with tdata 0x10..0x17 -> captures of 0x13 and 0x17 only, capture_count=2.
REQ-038 Capture and ack on the same edge -> data_valid remains 1, overrun unchanged; ack alone on the next edge -> data_valid=0.
REQ-039 enable dropped after 2 of 4 beats with DECIM=4, then re-enabled, then 4 beats 0xA0..0xA3 -> tready=0 while disabled, capture of 0xA3, no capture of earlier data.
REQ-040 aresetn pulsed low asynchronously mid-stream with data_out=0x5A5A -> all outputs 0 immediately, tready=0 until an edge with enable=1 after release.
REQ-041 Capture and overrun_clr on the same edge with data_valid=1 -> overrun=1; overrun_clr alone on the next edge -> overrun=0.
